// File: rtl/lock_arbiter_pkg.sv
// rtl/lock_arbiter_pkg.sv - shared OmpSsManager command/ack codes and arbiter FSM states
package OmpSsManager;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
  localparam int         LOCK_ID_L       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } lock_arb_state_t;

endpackage

// File: rtl/lock_owner_table.sv
// rtl/lock_owner_table.sv - per-lock valid/owner storage, one port, comb read, sync write
module lock_owner_table #(
  parameter int LOCK_ID_BITS = 8,
  parameter int ACC_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [LOCK_ID_BITS-1:0] addr,
  input  logic                    wr_en,
  input  logic                    wr_valid,
  input  logic [ACC_BITS-1:0]     wr_owner,
  output logic                    rd_valid,
  output logic [ACC_BITS-1:0]     rd_owner
);

  localparam int NUM_LOCKS = 2**LOCK_ID_BITS;

  logic [NUM_LOCKS-1:0] valid_q;
  logic [ACC_BITS-1:0]  owner_q [NUM_LOCKS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[addr] <= wr_valid;
    end
  end

  // Owner field is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_valid) begin
      owner_q[addr] <= wr_owner;
    end
  end

  assign rd_valid = valid_q[addr];
  assign rd_owner = owner_q[addr];

endmodule

// File: rtl/lock_arbiter.sv
// rtl/lock_arbiter.sv - lock/unlock command arbiter with owner table and ack stream
module lock_arbiter
  import OmpSsManager::*;
#(
  parameter  int MAX_ACCS     = 16,
  parameter  int LOCK_ID_BITS = 8,
  localparam int ACC_BITS     = $clog2(MAX_ACCS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic [63:0]           in_tdata,
  input  logic [ACC_BITS-1:0]   in_tid,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [63:0]           out_tdata,
  output logic [ACC_BITS-1:0]   out_tdest,
  output logic [LOCK_ID_BITS:0] held_count,
  output logic                  err_bad_unlock,
  output logic                  err_unknown_cmd
);

  localparam logic [LOCK_ID_BITS:0] CNT_ONE = 1;

  lock_arb_state_t state, state_next;

  logic [7:0]              cmd_q;
  logic [LOCK_ID_BITS-1:0] lock_id_q;
  logic [ACC_BITS-1:0]     tid_q;
  logic [7:0]              ack_q, ack_next;

  logic                    tbl_wr_en, tbl_wr_valid;
  logic                    tbl_rd_valid;
  logic [ACC_BITS-1:0]     tbl_rd_owner;
  logic                    cnt_inc, cnt_dec;
  logic                    owned_by_tid;

  logic unused_in_tdata;
  assign unused_in_tdata = ^in_tdata[63:LOCK_ID_L+LOCK_ID_BITS];

  lock_owner_table #(
    .LOCK_ID_BITS(LOCK_ID_BITS),
    .ACC_BITS    (ACC_BITS)
  ) u_table (
    .clk      (clk),
    .rstn     (rstn),
    .addr     (lock_id_q),
    .wr_en    (tbl_wr_en),
    .wr_valid (tbl_wr_valid),
    .wr_owner (tid_q),
    .rd_valid (tbl_rd_valid),
    .rd_owner (tbl_rd_owner)
  );

  assign owned_by_tid = tbl_rd_valid && (tbl_rd_owner == tid_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    ack_next        = ack_q;
    tbl_wr_en       = 1'b0;
    tbl_wr_valid    = 1'b0;
    cnt_inc         = 1'b0;
    cnt_dec         = 1'b0;
    err_bad_unlock  = 1'b0;
    err_unknown_cmd = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_tvalid) state_next = EXEC;
      end
      EXEC: begin
        if (cmd_q == CMD_LOCK_CODE) begin
          state_next = ACK;
          if (!tbl_rd_valid) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_valid = 1'b1;
            cnt_inc      = 1'b1;
            ack_next     = ACK_OK_CODE;
          end else if (owned_by_tid) begin
            ack_next = ACK_OK_CODE;
          end else begin
            ack_next = ACK_REJECT_CODE;
          end
        end else if (cmd_q == CMD_UNLOCK_CODE) begin
          state_next = IDLE;
          if (owned_by_tid) begin
            tbl_wr_en = 1'b1;
            cnt_dec   = 1'b1;
          end else begin
            err_bad_unlock = 1'b1;
          end
        end else begin
          state_next      = IDLE;
          err_unknown_cmd = 1'b1;
        end
      end
      ACK: begin
        if (out_tready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_q      <= '0;
      lock_id_q  <= '0;
      tid_q      <= '0;
      ack_q      <= '0;
      held_count <= '0;
    end else begin
      if (state == IDLE && in_tvalid) begin
        cmd_q     <= in_tdata[7:0];
        lock_id_q <= in_tdata[LOCK_ID_L +: LOCK_ID_BITS];
        tid_q     <= in_tid;
      end
      ack_q <= ack_next;
      if (cnt_inc) begin
        held_count <= held_count + CNT_ONE;
      end else if (cnt_dec) begin
        held_count <= held_count - CNT_ONE;
      end
    end
  end

  // Gating with rstn keeps in_tready low during reset yet high the first cycle after.
  assign in_tready  = (state == IDLE) && rstn;
  assign out_tvalid = (state == ACK);
  assign out_tdest  = (state == ACK) ? tid_q : '0;

  always_comb begin
    out_tdata = '0;
    if (state == ACK) begin
      out_tdata[7:0]  = ack_q;
      out_tdata[15:8] = 8'(lock_id_q);
    end
  end

endmodule

// File: tb/tb_lock_arbiter.sv
// tb/tb_lock_arbiter.sv - randomized self-checking bench for lock_arbiter
module tb_lock_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_tvalid;
  logic        in_tready;
  logic [63:0] in_tdata;
  logic [3:0]  in_tid;
  logic        out_tvalid;
  logic        out_tready;
  logic [63:0] out_tdata;
  logic [3:0]  out_tdest;
  logic [8:0]  held_count;
  logic        err_bad_unlock;
  logic        err_unknown_cmd;

  int checks   = 0;
  int failures = 0;

  bit       m_valid [256];
  int       m_owner [256];
  int       m_count;

  always #5 clk = ~clk;

  lock_arbiter #(.MAX_ACCS(16), .LOCK_ID_BITS(8)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .in_tvalid       (in_tvalid),
    .in_tready       (in_tready),
    .in_tdata        (in_tdata),
    .in_tid          (in_tid),
    .out_tvalid      (out_tvalid),
    .out_tready      (out_tready),
    .out_tdata       (out_tdata),
    .out_tdest       (out_tdest),
    .held_count      (held_count),
    .err_bad_unlock  (err_bad_unlock),
    .err_unknown_cmd (err_unknown_cmd)
  );

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = 0;
    end
    m_count = 0;
  endtask

  // Issues one command and checks its whole lifecycle against the model.
  task automatic do_cmd(input int acc, input logic [63:0] data, input int stall);
    logic [7:0]  cmd;
    int          id;
    bit          is_lock, is_unlock, exp_bad, exp_unk;
    logic [7:0]  exp_ack;
    logic [63:0] exp_data;
    int          n;
    cmd = data[7:0];
    id  = int'(data[15:8]);
    is_lock   = (cmd == 8'h04);
    is_unlock = (cmd == 8'h06);
    exp_unk   = !is_lock && !is_unlock;
    exp_bad   = is_unlock && !(m_valid[id] && m_owner[id] == acc);
    exp_ack   = (!m_valid[id] || m_owner[id] == acc) ? 8'h01 : 8'h00;
    exp_data  = {48'd0, data[15:8], exp_ack};

    n = 0;
    while (!in_tready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_tready) begin
      failures++;
      $display("FAIL ready_wait: in_tready=%0b required 1 within 20 cycles", in_tready);
      return;
    end
    in_tvalid  = 1'b1;
    in_tdata   = data;
    in_tid     = 4'(acc);
    out_tready = (stall == 0);
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    in_tdata  = {$urandom, $urandom};

    checks++;
    if (err_bad_unlock !== exp_bad || err_unknown_cmd !== exp_unk || out_tvalid !== 1'b0 ||
        in_tready !== 1'b0 || held_count !== 9'(m_count)) begin
      failures++;
      $display("FAIL exec_cycle cmd=%h: bad=%b unk=%b ov=%b rdy=%b cnt=%0d required bad=%b unk=%b ov=0 rdy=0 cnt=%0d",
               cmd, err_bad_unlock, err_unknown_cmd, out_tvalid, in_tready, held_count,
               exp_bad, exp_unk, m_count);
    end

    if (is_lock && !m_valid[id]) begin
      m_valid[id] = 1'b1;
      m_owner[id] = acc;
      m_count++;
    end else if (is_unlock && !exp_bad) begin
      m_valid[id] = 1'b0;
      m_count--;
    end

    @(posedge clk); #1;
    if (is_lock) begin
      checks++;
      if (out_tvalid !== 1'b1 || out_tdata !== exp_data || out_tdest !== 4'(acc) ||
          in_tready !== 1'b0 || held_count !== 9'(m_count) || err_bad_unlock !== 1'b0) begin
        failures++;
        $display("FAIL ack_cycle: ov=%b data=%h dest=%0d rdy=%b cnt=%0d required ov=1 data=%h dest=%0d rdy=0 cnt=%0d",
                 out_tvalid, out_tdata, out_tdest, in_tready, held_count, exp_data, acc, m_count);
      end
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        checks++;
        if (out_tvalid !== 1'b1 || out_tdata !== exp_data || out_tdest !== 4'(acc) || in_tready !== 1'b0) begin
          failures++;
          $display("FAIL ack_stall: ov=%b data=%h dest=%0d rdy=%b required ov=1 data=%h dest=%0d rdy=0",
                   out_tvalid, out_tdata, out_tdest, in_tready, exp_data, acc);
        end
      end
      out_tready = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (in_tready !== 1'b1 || out_tvalid !== 1'b0 || held_count !== 9'(m_count) ||
        err_bad_unlock !== 1'b0 || err_unknown_cmd !== 1'b0) begin
      failures++;
      $display("FAIL return_idle cmd=%h: rdy=%b ov=%b cnt=%0d bad=%b unk=%b required rdy=1 ov=0 cnt=%0d pulses 0",
               cmd, in_tready, out_tvalid, held_count, err_bad_unlock, err_unknown_cmd, m_count);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_tvalid = 1'b0; in_tdata = '0; in_tid = '0; out_tready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_tready !== 1'b0 || out_tvalid !== 1'b0 || out_tdata !== 64'd0 || out_tdest !== 4'd0 ||
        held_count !== 9'd0 || err_bad_unlock !== 1'b0 || err_unknown_cmd !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b ov=%b data=%h dest=%0d cnt=%0d bad=%b unk=%b required all 0",
               in_tready, out_tvalid, out_tdata, out_tdest, held_count, err_bad_unlock, err_unknown_cmd);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (in_tready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: in_tready=%b required 1", in_tready);
    end
  endtask

  task automatic test_lock_basic();
    do_cmd(3, 64'h0504, 0);
  endtask

  task automatic test_contention();
    do_cmd(7, 64'h0504, 0);
  endtask

  task automatic test_bad_unlock();
    do_cmd(7, 64'h0506, 0);
    do_cmd(3, 64'h0506, 0);
    do_cmd(7, 64'h0504, 0);
  endtask

  task automatic test_back_to_back_stall();
    do_cmd(2, 64'h1104, 5);
    do_cmd(2, 64'h1106, 0);
  endtask

  task automatic test_all_locks();
    test_reset();
    for (int i = 0; i < 256; i++) begin
      do_cmd(3, {48'd0, 8'(i), 8'h04}, 0);
    end
    checks++;
    if (held_count !== 9'd256) begin
      failures++;
      $display("FAIL all_locks_count: held_count=%0d required 256", held_count);
    end
    do_cmd(3, 64'hFF04, 0);
  endtask

  task automatic test_reset_mid_op();
    test_reset();
    do_cmd(4, 64'h2204, 0);
    while (!in_tready) begin
      @(posedge clk); #1;
    end
    in_tvalid = 1'b1; in_tdata = 64'h3304; in_tid = 4'd5;
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_tvalid !== 1'b0 || in_tready !== 1'b0 || held_count !== 9'd0 || out_tdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_op: ov=%b rdy=%b cnt=%0d data=%h required 0", out_tvalid, in_tready,
               held_count, out_tdata);
    end
    model_clear();
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    checks++;
    if (in_tready !== 1'b1 || out_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL after_mid_reset: rdy=%b ov=%b required rdy=1 ov=0", in_tready, out_tvalid);
    end
    do_cmd(9, 64'h3304, 0);
    do_cmd(9, 64'h2204, 0);
  endtask

  task automatic test_unknown_cmd();
    do_cmd(1, 64'h0509, 0);
    do_cmd(1, 64'hDEAD_0000_0000_4400, 0);
  endtask

  task automatic test_random();
    logic [63:0] data;
    int r;
    test_reset();
    for (int k = 0; k < 300; k++) begin
      data = {$urandom, $urandom};
      data[15:8] = 8'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 5)      data[7:0] = 8'h04;
      else if (r < 9) data[7:0] = 8'h06;
      else begin
        data[7:0] = 8'($urandom);
        if (data[7:0] == 8'h04 || data[7:0] == 8'h06) data[7:0] = 8'hA5;
      end
      do_cmd($urandom_range(0, 3), data, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_contention();
    test_bad_unlock();
    test_back_to_back_stall();
    test_unknown_cmd();
    test_all_locks();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lock_arbiter.md
LOCK_ARBITER -- requirements
Module: lock_arbiter

Interface
REQ-001 SHALL have parameter MAX_ACCS, default 16, meaning the number of accelerators; ACC_BITS = $clog2(MAX_ACCS).
REQ-002 SHALL have parameter LOCK_ID_BITS, default 8, meaning the lock ID width; NUM_LOCKS = 2**LOCK_ID_BITS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in_tvalid (in, 1), in_tready (out, 1), in_tdata (in, 64) and in_tid (in, ACC_BITS): the command stream and its source accelerator.
REQ-006 SHALL have ports out_tvalid (out, 1), out_tready (in, 1), out_tdata (out, 64) and out_tdest (out, ACC_BITS): the ack stream and its target accelerator.
REQ-007 SHALL have port held_count, output, LOCK_ID_BITS+1 bits: the number of locks currently held.
REQ-008 SHALL have ports err_bad_unlock and err_unknown_cmd, output, 1 bit each: single-cycle error pulses.

Function
REQ-009 SHALL decode cmd = in_tdata[7:0] and lock_id = in_tdata[8+LOCK_ID_BITS-1:8]; lock code 0x04, unlock code 0x06.
REQ-010 SHALL hold an owner table: per lock, a valid bit plus an ACC_BITS owner.
REQ-011 SHALL use FSM states IDLE, EXEC and ACK; in_tready = 1 only in IDLE.
REQ-012 SHALL register cmd, lock_id and in_tid on an IDLE handshake and move to EXEC.
REQ-013 SHALL, for a lock command in EXEC:
- free lock -> set valid and owner = tid, ack 0x01;
- already owned by tid -> ack 0x01, table unchanged;
- owned by another accelerator -> ack 0x00, table unchanged.
Then go to ACK.
REQ-014 SHALL, for an unlock command in EXEC:
- owned by tid -> clear valid;
- free, or owned by another accelerator -> table unchanged, pulse err_bad_unlock.
Then go to IDLE; no ack.
REQ-015 SHALL, for any other cmd in EXEC, pulse err_unknown_cmd and return to IDLE.
REQ-016 SHALL, in ACK, drive out_tvalid = 1 with out_tdata[7:0] = ack code, out_tdata[15:8] = lock_id zero-extended, other bits 0, and out_tdest = tid.
REQ-017 SHALL hold out_tdata and out_tdest stable while out_tvalid = 1 and out_tready = 0; go to IDLE on the cycle out_tvalid & out_tready.
REQ-018 SHALL have these latencies:
- lock: handshake at cycle T -> out_tvalid at T+2 -> in_tready again the cycle after ack acceptance;
- unlock: in_tready again at T+2.
REQ-019 SHALL update held_count in the same cycle as the table change (+1 on grant of a free lock, -1 on valid unlock); the count saturates at NUM_LOCKS by construction.
REQ-020 SHALL make a table change in EXEC visible to the next command's EXEC; back-to-back commands need no bypass.
REQ-021 SHALL allow one accelerator to hold any number of distinct locks simultaneously.

Reset
REQ-022 SHALL, while rstn = 0, asynchronously force:
- FSM to IDLE; all table valid bits to 0; held_count to 0;
- out_tvalid, out_tdata, out_tdest, err_bad_unlock, err_unknown_cmd to 0;
- in_tready to 0.
REQ-023 SHALL discard an in-flight command on mid-operation reset: no ack, no table change.
REQ-024 SHALL drive in_tready = 1 in the first cycle after rstn deasserts.

Structure
REQ-025 SHALL take CMD_LOCK_CODE, CMD_UNLOCK_CODE, ACK_OK_CODE, ACK_REJECT_CODE, LOCK_ID_L and the FSM state enum from the shared OmpSsManager package; the state enum is added to that package.
REQ-026 SHALL place the owner table in a sub-module lock_owner_table with one read/write port, combinational read and synchronous write.

Verification
REQ-027 SHALL cover: acc 3 locks id 0x05 (in_tdata = 0x0504) -> ack out_tdata = 0x0501, out_tdest = 3 at T+2, held_count = 1.
REQ-028 SHALL cover: acc 7 locks 0x05 while acc 3 holds it -> ack 0x0500, out_tdest = 7, held_count stays 1.
REQ-029 SHALL cover: acc 7 unlocks 0x05 (0x0506) -> err_bad_unlock one-cycle pulse, no ack; then acc 3 unlocks 0x05 -> held_count = 0, and a subsequent acc 7 lock gets 0x01.
REQ-030 SHALL cover: out_tready held at 0 for 5 cycles during an ack -> out_tdata/out_tdest stable, in_tready = 0 throughout, next command accepted the cycle after acceptance.
REQ-031 SHALL cover: acc 3 locks all 256 ids -> held_count = 256, and a re-lock of 0xFF by acc 3 gets 0x01.
REQ-032 SHALL cover: rstn asserted in EXEC of a lock -> no ack, held_count = 0, and the lock is free afterwards; cmd 0x09 -> err_unknown_cmd pulse.
